fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end of the RV32I core. Holds the PC, issues word requests to instruction memory over a grant/valid handshake and buffers returned words in a 2-entry queue. Presents each instruction with its PC and a pre-decoded 3-bit immediate-type code to the decode stage, where `imm_extractor` consumes `id_ir` and `id_imm_type`. Supports pipeline stall through `id_ready` and control-flow redirect with flush of in-flight fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address, equal to `pc`.
- `imem_gnt` in 1: request accepted this cycle when `imem_req` is also high.
- `imem_rvalid` in 1: response word valid. Responses return in order, at least 1 cycle after grant.
- `imem_rdata` in 32: response word.
- `redirect` in 1: control-flow change; flush and refetch.
- `redirect_pc` in 32: new PC. Bits [1:0] are ignored and treated as 0.
- `id_ready` in 1: decode stage accepts the head entry.
- `id_valid` out 1: head entry valid.
- `id_ir` out 32: instruction word.
- `id_pc` out 32: PC of `id_ir`.
- `id_imm_type` out 3: immediate class for `imm_extractor`.

## Operation
- State:
  - `pc`: next fetch address.
  - `resp_pc`: PC of the next kept response.
  - `outstanding`: 0–2, granted requests not yet returned, including doomed ones.
  - `drop_cnt`: 0–2, responses still to be discarded.
  - 2-entry FIFO of {pc, ir, imm_type}, with `count` 0–2.
- Request rule:
  - `imem_req = !redirect && (outstanding + count - pop) < 2`, where `pop = id_valid & id_ready`.
  - This is a combinational path from `id_ready` to `imem_req` and is intentional.
- Grant (`imem_req & imem_gnt`): `pc <= pc + 4` (mod 2^32), `outstanding` +1.
- Response (`imem_rvalid`): `outstanding` −1.
  - If `drop_cnt > 0`: decrement `drop_cnt` and discard the word.
  - Otherwise: push {`resp_pc`, `imem_rdata`, decode(`imem_rdata`)} and set `resp_pc <= resp_pc + 4`.
  - A push and a pop in the same cycle are both honoured.
  - Overflow cannot occur under the request rule; the bench asserts this.
- Redirect (highest priority):
  - `pc` and `resp_pc` are both loaded with `{redirect_pc[31:2], 2'b00}`.
  - The FIFO is cleared, and any same-cycle pop or push is void.
  - `drop_cnt <= outstanding - imem_rvalid`.
  - `outstanding <= outstanding - imem_rvalid`.
  - No request is issued in the redirect cycle.
- Back-to-back redirects reload `pc` each time and recompute `drop_cnt`.
- Immediate-type decode on `ir[6:0]`:
  - 0010011 with funct3 001 or 101 → 3'b101 (shamt).
  - 0010011 with any other funct3 → 3'b000.
  - 0000011, 1100111, 1110011 → 3'b000 (I).
  - 1100011 → 3'b001 (B).
  - 0100011 → 3'b010 (S).
  - 0110111, 0010111 → 3'b011 (U).
  - 1101111 → 3'b100 (J).
  - All other opcodes → 3'b000.
- Outputs `id_*` are driven from the FIFO head. While `id_valid` is 0 their values are don't-care, but they must hold the last head value (no X from reset).

## Timing
- Reset values:
  - `pc = resp_pc = RESET_PC`.
  - `outstanding = drop_cnt = count = 0`.
  - `id_valid = 0`, `id_ir = 0`, `id_pc = RESET_PC`, `id_imm_type = 0`.
  - `imem_req` is 0 while `rst` is high and is 1 in the first cycle after release.
- Reset mid-operation: all state returns to reset values immediately. Responses arriving after release for pre-reset requests are not tracked and are the memory's responsibility. The bench drives none.
- Latency: a response arriving in cycle t sets `id_valid` in cycle t+1 (registered FIFO).
- Throughput: sustains 1 instruction/cycle with gnt=1, 1-cycle response latency and `id_ready=1`.
- Stall: with `id_ready=0`, at most 2 entries plus in-flight requests fit. No request is issued once `outstanding + count = 2`.
- `id_*` remain stable while `id_valid & !id_ready`.

## Test plan
- Streaming:
  - Stimulus: reset, gnt=1, 1-cycle latency, words 0x00500093, 0x00209113, 0xFE000EE3, 0x00112023, 0x123450B7, 0x008000EF.
  - Required: `id_pc` 0,4,8,C,10,14; `id_imm_type` 000,101,001,010,011,100, one per cycle.
- Stall:
  - Stimulus: `id_ready=0` for 5 cycles.
  - Required: `count` saturates at 2; `imem_req` is 0 while `outstanding + count = 2`; `id_ir` stays at the first word. After release, no word is lost or duplicated.
- Redirect with two in flight:
  - Stimulus: `redirect_pc=0x100` while outstanding=2.
  - Required: both stale responses are dropped; the first `id_pc` is 0x100, then 0x104.
- Redirect coinciding with response and pop:
  - Stimulus: `redirect`, `imem_rvalid` and `pop` in the same cycle.
  - Required: the FIFO is empty next cycle; `drop_cnt = outstanding - 1`.
- Grant backpressure and unaligned redirect:
  - Stimulus: `imem_gnt` toggling 1,0,0,1; `redirect_pc=0x203`.
  - Required: `imem_addr` holds while ungranted; fetch resumes at 0x200.
- Async reset mid-stream:
  - Stimulus: assert `rst` between clock edges.
  - Required: `id_valid` falls immediately; `imem_addr=RESET_PC` on release.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch front end with 2-entry instruction queue, stall and redirect flush
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_ir,
  output logic [31:0] id_pc,
  output logic [2:0]  id_imm_type
);
  logic [31:0] r_pc, r_resp_pc;
  logic [1:0]  r_outstanding, r_drop_cnt, r_count;
  logic [66:0] r_q0, r_q1;
  logic        w_pop, w_push, w_drop, w_gnt, w_wr1;
  logic [2:0]  w_occ, w_imm, w_f3;
  logic [6:0]  w_op;
  logic [66:0] w_ent;
  logic [31:0] w_rpc;

  assign w_op  = imem_rdata[6:0];
  assign w_f3  = imem_rdata[14:12];
  assign w_imm = (w_op == 7'b0010011) ? ((w_f3 == 3'b001 || w_f3 == 3'b101) ? 3'b101 : 3'b000) :
                 (w_op == 7'b1100011) ? 3'b001 :
                 (w_op == 7'b0100011) ? 3'b010 :
                 (w_op == 7'b0110111 || w_op == 7'b0010111) ? 3'b011 :
                 (w_op == 7'b1101111) ? 3'b100 : 3'b000;

  assign id_valid    = r_count != 2'd0;
  assign id_pc       = r_q0[66:35];
  assign id_ir       = r_q0[34:3];
  assign id_imm_type = r_q0[2:0];
  assign imem_addr   = r_pc;

  assign w_pop  = id_valid & id_ready;
  assign w_drop = imem_rvalid && r_drop_cnt != 2'd0;
  assign w_push = imem_rvalid && !w_drop && !redirect;
  // Occupancy counts in-flight requests too, so a granted word always has a slot
  assign w_occ    = {1'b0, r_outstanding} + {1'b0, r_count} - {2'b00, w_pop};
  assign imem_req = !rst && !redirect && w_occ < 3'd2;
  assign w_gnt    = imem_req & imem_gnt;
  assign w_wr1    = (r_count - {1'b0, w_pop}) != 2'd0;
  assign w_ent    = {r_resp_pc, imem_rdata, w_imm};
  assign w_rpc    = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= 2'd0;
      r_drop_cnt    <= 2'd0;
      r_count       <= 2'd0;
      r_q0          <= {RESET_PC, 32'd0, 3'd0};
      r_q1          <= {RESET_PC, 32'd0, 3'd0};
    end else if (redirect) begin
      r_pc          <= w_rpc;
      r_resp_pc     <= w_rpc;
      r_count       <= 2'd0;
      r_outstanding <= r_outstanding - {1'b0, imem_rvalid};
      r_drop_cnt    <= r_outstanding - {1'b0, imem_rvalid};
    end else begin
      if (w_gnt) r_pc <= r_pc + 32'd4;
      r_outstanding <= r_outstanding + {1'b0, w_gnt} - {1'b0, imem_rvalid};
      if (w_drop) r_drop_cnt <= r_drop_cnt - 2'd1;
      if (w_push) r_resp_pc <= r_resp_pc + 32'd4;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      r_q0    <= (w_push && !w_wr1) ? w_ent : w_pop ? r_q1 : r_q0;
      if (w_push && w_wr1) r_q1 <= w_ent;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with an in-order memory model
module tb_fetch_unit;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [2:0]  it;
  } ent_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid, redirect, id_ready, id_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, id_ir, id_pc;
  logic [2:0]  id_imm_type;

  int errors = 0, checks = 0, cyc = 0;
  ent_t        exp_q[$], pops[$];
  logic [31:0] q_addr[$];
  bit          q_doom[$];
  int          q_cyc[$];
  logic [31:0] mpc = 32'd0, rsp_addr = 32'd0;
  bit          rsp_doom = 1'b0, resp_en = 1'b1;
  logic [31:0] stream [0:5] = '{32'h00500093, 32'h00209113, 32'hFE000EE3,
                                32'h00112023, 32'h123450B7, 32'h008000EF};
  logic [2:0]  stream_it [0:5] = '{3'b000, 3'b101, 3'b001, 3'b010, 3'b011, 3'b100};

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_ir(id_ir),
    .id_pc(id_pc), .id_imm_type(id_imm_type)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [2:0] dec(input logic [31:0] ir);
    case (ir[6:0])
      7'h13:        dec = (ir[13:12] == 2'b01) ? 3'b101 : 3'b000;
      7'h63:        dec = 3'b001;
      7'h23:        dec = 3'b010;
      7'h37, 7'h17: dec = 3'b011;
      7'h6F:        dec = 3'b100;
      default:      dec = 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    logic [6:0]  op;
    int k;
    if (a < 32'd24) return stream[int'(a >> 2)];
    w = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    k = int'((a >> 2) % 32'd10);
    case (k)
      0: op = 7'h13; 1: op = 7'h03; 2: op = 7'h67; 3: op = 7'h73; 4: op = 7'h63;
      5: op = 7'h23; 6: op = 7'h37; 7: op = 7'h17; 8: op = 7'h6F;
      default: op = 7'h33;
    endcase
    return {w[31:7], op};
  endfunction

  // Observe one cycle at the falling edge and advance the reference model
  task automatic sample();
    int outst, drops, occ;
    bit mvalid, pop, mreq;
    ent_t e;
    outst = q_addr.size() + int'(imem_rvalid);
    drops = int'(imem_rvalid && rsp_doom);
    foreach (q_doom[i]) drops += int'(q_doom[i]);
    mvalid = exp_q.size() != 0;
    pop = mvalid && id_ready;
    occ = outst + exp_q.size() - int'(pop);
    mreq = !redirect && occ < 2;
    check("outstanding", 32'(dut.r_outstanding), 32'(outst));
    check("drop_cnt", 32'(dut.r_drop_cnt), 32'(drops));
    check("count", 32'(dut.r_count), 32'(exp_q.size()));
    check("id_valid", 32'(id_valid), 32'(mvalid));
    check("imem_req", 32'(imem_req), 32'(mreq));
    check("imem_addr", imem_addr, mpc);
    if (mvalid) begin
      check("id_pc", id_pc, exp_q[0].pc);
      check("id_ir", id_ir, exp_q[0].ir);
      check("id_imm_type", 32'(id_imm_type), 32'(exp_q[0].it));
    end
    if (pop && !redirect) pops.push_back(exp_q.pop_front());
    if (imem_rvalid && !rsp_doom && !redirect) begin
      e.pc = rsp_addr;
      e.ir = imem_rdata;
      e.it = dec(imem_rdata);
      exp_q.push_back(e);
      check("fifo_bound", 32'(exp_q.size() <= 2), 32'd1);
    end
    if (mreq && imem_gnt) begin
      q_addr.push_back(mpc);
      q_doom.push_back(1'b0);
      q_cyc.push_back(cyc);
      mpc += 32'd4;
    end
    if (redirect) begin
      foreach (q_doom[i]) q_doom[i] = 1'b1;
      exp_q.delete();
      mpc = redirect_pc & 32'hFFFF_FFFC;
    end
  endtask

  task automatic drive_mem();
    if (resp_en && q_addr.size() != 0 && q_cyc[0] < cyc) begin
      rsp_addr = q_addr.pop_front();
      rsp_doom = q_doom.pop_front();
      void'(q_cyc.pop_front());
      imem_rvalid = 1'b1;
      imem_rdata = mem_word(rsp_addr);
    end else begin
      rsp_doom = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    drive_mem();
  endtask

  initial begin
    imem_gnt = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; id_ready = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_ir", id_ir, 32'd0);
    check("rst_imm", 32'(id_imm_type), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;

    // streaming: one instruction per cycle once the pipe fills
    pops.delete();
    repeat (8) cycle();
    check("stream_n", 32'(pops.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < pops.size()) begin
        check("stream_pc", pops[i].pc, 32'(i * 4));
        check("stream_imm", 32'(pops[i].it), 32'(stream_it[i]));
      end

    // stall
    id_ready = 1'b0;
    repeat (5) cycle();
    check("stall_count", 32'(dut.r_count), 32'd2);
    check("stall_req", 32'(imem_req), 32'd0);
    id_ready = 1'b1;
    repeat (6) cycle();

    // redirect coinciding with a response and a pop
    check("pre_flush_valid", 32'(id_valid), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h40;
    cycle();
    redirect = 1'b0;
    check("flush_empty", 32'(id_valid), 32'd0);
    repeat (4) cycle();

    // redirect with two requests in flight
    resp_en = 1'b0;
    repeat (4) cycle();
    check("two_inflight", 32'(dut.r_outstanding), 32'd2);
    pops.delete();
    redirect = 1'b1; redirect_pc = 32'h100; resp_en = 1'b1;
    cycle();
    redirect = 1'b0;
    repeat (8) cycle();
    check("redir_n", 32'(pops.size() >= 2), 32'd1);
    if (pops.size() >= 2) begin
      check("redir_pc0", pops[0].pc, 32'h100);
      check("redir_pc1", pops[1].pc, 32'h104);
    end

    // grant backpressure and unaligned redirect
    imem_gnt = 1'b0;
    repeat (4) cycle();
    redirect = 1'b1; redirect_pc = 32'h203; imem_gnt = 1'b1;
    cycle();
    redirect = 1'b0;
    check("unal_addr", imem_addr, 32'h200);
    cycle();
    check("gnt_addr1", imem_addr, 32'h204);
    imem_gnt = 1'b0;
    cycle();
    check("hold_addr1", imem_addr, 32'h204);
    cycle();
    check("hold_addr2", imem_addr, 32'h204);
    imem_gnt = 1'b1;
    cycle();
    check("gnt_addr2", imem_addr, 32'h208);

    // asynchronous reset between clock edges
    repeat (6) cycle();
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", 32'(id_valid), 32'd0);
    check("ar_req", 32'(imem_req), 32'd0);
    check("ar_addr", imem_addr, 32'd0);
    q_addr.delete(); q_doom.delete(); q_cyc.delete(); exp_q.delete();
    mpc = 32'd0; imem_rvalid = 1'b0; rsp_doom = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("ar_release_addr", imem_addr, 32'd0);
    check("ar_release_req", 32'(imem_req), 32'd1);
    repeat (4) cycle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      imem_gnt = $urandom_range(0, 3) != 0;
      id_ready = $urandom_range(0, 3) != 0;
      resp_en = $urandom_range(0, 2) != 0;
      redirect = $urandom_range(0, 15) == 0;
      redirect_pc = $urandom;
      cycle();
    end

    redirect = 1'b0; imem_gnt = 1'b0; id_ready = 1'b1; resp_en = 1'b1;
    repeat (8) cycle();
    check("drain_valid", 32'(id_valid), 32'd0);
    check("drain_out", 32'(dut.r_outstanding), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
